// File: rtl/exe_issue_latch_if.sv
// rtl/exe_issue_latch_if.sv - decode/execute handshake bundle for the issue latch
interface exe_issue_latch_if #(
    parameter int CNT_W = 2
);
    logic [31:0]      ID_OPCODE;
    logic             ID_VALID;
    logic [CNT_W-1:0] ID_NCYC;
    logic             HOLD;
    logic             FLUSH;
    logic [31:0]      OPCODE;
    logic [CNT_W-1:0] GCnt;
    logic             EX_VALID;
    logic             EX_LAST;
    logic             ID_STALL;

    modport master (
        output ID_OPCODE, ID_VALID, ID_NCYC, HOLD, FLUSH,
        input  OPCODE, GCnt, EX_VALID, EX_LAST, ID_STALL
    );

    modport slave (
        input  ID_OPCODE, ID_VALID, ID_NCYC, HOLD, FLUSH,
        output OPCODE, GCnt, EX_VALID, EX_LAST, ID_STALL
    );
endinterface

// File: rtl/exe_issue_latch.sv
// rtl/exe_issue_latch.sv - decode->execute pipeline register and multi-cycle sequencer
module exe_issue_latch #(
    parameter logic [31:0] NOP_OPCODE = 32'hE1A00000,
    parameter int          CNT_W      = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    exe_issue_latch_if.slave       bus
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      opcode_q, opcode_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic [CNT_W-1:0] ncyc_q, ncyc_d;
    logic             ex_last;
    logic             id_stall;

    // The instruction is on its final cycle once the counter reaches the latched length.
    assign ex_last  = (state_q == EXEC) && (gcnt_q == ncyc_q);
    assign id_stall = bus.HOLD || ((state_q == EXEC) && !ex_last);

    assign bus.OPCODE   = opcode_q;
    assign bus.GCnt     = gcnt_q;
    assign bus.EX_VALID = (state_q == EXEC);
    assign bus.EX_LAST  = ex_last;
    assign bus.ID_STALL = id_stall;

    // Next-state selection: flush beats hold, hold beats advance, advance beats accept.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        gcnt_d   = gcnt_q;
        ncyc_d   = ncyc_q;
        if (bus.FLUSH) begin
            // Kill the EX instruction; the decode word is refetched, not accepted.
            state_d  = IDLE;
            opcode_d = NOP_OPCODE;
            gcnt_d   = '0;
            ncyc_d   = '0;
        end else if (bus.HOLD) begin
            state_d  = state_q;
        end else if ((state_q == EXEC) && !ex_last) begin
            // Mid multi-cycle op: step the cycle index, keep word and length.
            gcnt_d   = gcnt_q + 1'b1;
        end else if (bus.ID_VALID) begin
            state_d  = EXEC;
            opcode_d = bus.ID_OPCODE;
            ncyc_d   = bus.ID_NCYC;
            gcnt_d   = '0;
        end else begin
            // No instruction offered: issue a bubble.
            state_d  = IDLE;
            opcode_d = NOP_OPCODE;
            gcnt_d   = '0;
            ncyc_d   = '0;
        end
    end

    // State register with synchronous reset that abandons any in-flight instruction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            opcode_q <= NOP_OPCODE;
            gcnt_q   <= '0;
            ncyc_q   <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            gcnt_q   <= gcnt_d;
            ncyc_q   <= ncyc_d;
        end
    end

endmodule
